// File: rtl/acc_drain.sv
// acc_drain: pops Len words from an upstream FIFO, sums them into a signed
// AccWidth accumulator with sticky overflow, then holds the result until
// the downstream side accepts it.
module acc_drain #(
    parameter int DataWidth  = 32,
    parameter int AccWidth   = 40,
    parameter int CountWidth = 8
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic                  Start,
    input  logic [CountWidth-1:0] Len,
    input  logic                  Empty,
    input  logic [DataWidth-1:0]  FifoData,
    output logic                  Pop,
    output logic [AccWidth-1:0]   Sum,
    output logic                  SumValid,
    input  logic                  SumReady,
    output logic                  Busy,
    output logic                  Ovf
);

    localparam int ExtWidth = AccWidth - DataWidth;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [CountWidth-1:0] remaining;
    logic                  pop_d;
    logic [AccWidth-1:0]   acc;
    logic                  ovf_q;
    logic                  sum_valid_q;

    logic [AccWidth-1:0]   addend;
    logic [AccWidth-1:0]   acc_sum;
    logic                  add_ovf;

    // Sign-extend the FIFO word and flag signed overflow of the addition:
    // operands agree in sign but the result does not.
    assign addend  = {{ExtWidth{FifoData[DataWidth-1]}}, FifoData};
    assign acc_sum = acc + addend;
    assign add_ovf = (acc[AccWidth-1] == addend[AccWidth-1]) &&
                     (acc_sum[AccWidth-1] != acc[AccWidth-1]);

    // Pop only while words are still owed and the FIFO has one to give.
    assign Pop      = (state == DRAIN) && (remaining != '0) && !Empty;
    assign Busy     = (state != IDLE);
    assign Sum      = acc;
    assign Ovf      = ovf_q;
    assign SumValid = sum_valid_q;

    // Job control, word counting and accumulation.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state       <= IDLE;
            remaining   <= '0;
            pop_d       <= 1'b0;
            acc         <= '0;
            ovf_q       <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pop_d <= 1'b0;
                    if (Start) begin
                        remaining <= Len;
                        acc       <= '0;
                        ovf_q     <= 1'b0;
                        if (Len != '0) begin
                            state <= DRAIN;
                        end else begin
                            state       <= DONE;
                            sum_valid_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    pop_d <= Pop;
                    if (Pop) begin
                        remaining <= remaining - 1'b1;
                    end
                    if (pop_d) begin
                        acc <= acc_sum;
                        if (add_ovf) begin
                            ovf_q <= 1'b1;
                        end
                    end
                    // Once nothing is owed, the only outstanding word is the
                    // one being added on this edge (if pop_d), so the result
                    // is final after this edge.
                    if (remaining == '0) begin
                        state       <= DONE;
                        sum_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    pop_d <= 1'b0;
                    if (SumReady) begin
                        state       <= IDLE;
                        sum_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    sum_valid_q <= 1'b0;
                    pop_d       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain: two instances (40-bit and 33-bit accumulators) fed by
// behavioural FIFOs; results compared against a plain-integer summation model.
module tb_acc_drain;

    typedef logic [31:0] wq_t[$];

    typedef struct {
        int             len;
        logic [3:0][31:0] w;
        logic [63:0]    exp_sum;
        logic           exp_ovf;
        int             exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        aclr_n;
    logic        start_a, start_b, rdy_a, rdy_b;
    logic [7:0]  len_a, len_b;
    logic        empty_a, empty_b;
    logic [31:0] fd_a, fd_b;
    logic        pop_a, pop_b, sv_a, sv_b, busy_a, busy_b, ovf_a, ovf_b;
    logic [39:0] sum_a;
    logic [32:0] sum_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    int wp_a = 0, rp_a = 0, pops_a = 0;
    int wp_b = 0, rp_b = 0, pops_b = 0;

    always #5 clk = ~clk;

    acc_drain #(.DataWidth(32), .AccWidth(40), .CountWidth(8)) u_dut_a (
        .clk(clk), .aclr_n(aclr_n), .Start(start_a), .Len(len_a),
        .Empty(empty_a), .FifoData(fd_a), .Pop(pop_a), .Sum(sum_a),
        .SumValid(sv_a), .SumReady(rdy_a), .Busy(busy_a), .Ovf(ovf_a)
    );

    acc_drain #(.DataWidth(32), .AccWidth(33), .CountWidth(8)) u_dut_b (
        .clk(clk), .aclr_n(aclr_n), .Start(start_b), .Len(len_b),
        .Empty(empty_b), .FifoData(fd_b), .Pop(pop_b), .Sum(sum_b),
        .SumValid(sv_b), .SumReady(rdy_b), .Busy(busy_b), .Ovf(ovf_b)
    );

    // Behavioural FIFOs: read data appears the cycle after a pop.
    assign empty_a = (rp_a == wp_a);
    assign empty_b = (rp_b == wp_b);

    always @(posedge clk) begin
        if (pop_a) begin
            fd_a   <= mem_a[rp_a % 1024];
            rp_a   <= rp_a + 1;
            pops_a <= pops_a + 1;
        end
        if (pop_b) begin
            fd_b   <= mem_b[rp_b % 1024];
            rp_b   <= rp_b + 1;
            pops_b <= pops_b + 1;
        end
    end

    // A pop against an empty FIFO is always an error.
    always @(negedge clk) begin
        if (pop_a && empty_a) begin
            total++; bad++;
            $display("FAIL pop_on_empty_a act=1 exp=0 t=%0t", $time);
        end
        if (pop_b && empty_b) begin
            total++; bad++;
            $display("FAIL pop_on_empty_b act=1 exp=0 t=%0t", $time);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int which, input logic [31:0] w);
        if (which == 0) begin
            mem_a[wp_a % 1024] = w;
            wp_a++;
        end else begin
            mem_b[wp_b % 1024] = w;
            wp_b++;
        end
    endtask

    function automatic logic get_sv(input int which);
        return (which == 0) ? sv_a : sv_b;
    endfunction

    function automatic logic get_busy(input int which);
        return (which == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic [63:0] get_sum(input int which);
        return (which == 0) ? {24'd0, sum_a} : {31'd0, sum_b};
    endfunction

    function automatic int get_pops(input int which);
        return (which == 0) ? pops_a : pops_b;
    endfunction

    // Reference: exact integer sum of signed words, wrapped into the signed
    // aw-bit range after each add; any excursion outside that range is sticky.
    function automatic void model(input int aw, input wq_t w,
                                  output logic [63:0] esum, output logic eovf);
        longint acc, t, span, hi, lo;
        span = longint'(1) <<< aw;
        hi   = span / 2 - 1;
        lo   = -(span / 2);
        acc  = 0;
        eovf = 1'b0;
        foreach (w[i]) begin
            t = acc + longint'($signed(w[i]));
            if (t > hi) begin
                eovf = 1'b1;
                t    = t - span;
            end else if (t < lo) begin
                eovf = 1'b1;
                t    = t + span;
            end
            acc = t;
        end
        esum = 64'(acc) & 64'(span - 1);
    endfunction

    task automatic drive(input int which, input logic st, input logic [7:0] ln);
        if (which == 0) begin
            start_a = st; len_a = ln;
        end else begin
            start_b = st; len_b = ln;
        end
    endtask

    task automatic set_rdy(input int which, input logic r);
        if (which == 0) rdy_a = r; else rdy_b = r;
    endtask

    // Start a job, then wait for SumValid while Start/Len wander randomly.
    task automatic run_job(input int which, input int len, input int max_cyc, output int lat);
        logic [7:0] l8;
        l8 = len[7:0];
        drive(which, 1'b1, l8);
        tick;
        lat = 1;
        while (!get_sv(which) && lat < max_cyc) begin
            drive(which, 1'($urandom_range(0, 1)), 8'($urandom));
            tick;
            lat++;
        end
        drive(which, 1'b0, 8'd0);
    endtask

    task automatic ack(input int which, input string tag);
        set_rdy(which, 1'b1);
        tick;
        set_rdy(which, 1'b0);
        chk({tag, "_valid_drop"}, 64'(get_sv(which)), 64'd0);
        chk({tag, "_idle"}, 64'(get_busy(which)), 64'd0);
    endtask

    task automatic job_check(input int which, input string tag, input wq_t w,
                             input logic [63:0] esum, input logic eovf,
                             input int exp_lat, input bit do_ack, output int lat);
        int p0;
        p0 = get_pops(which);
        run_job(which, w.size(), 4 * w.size() + 30, lat);
        chk({tag, "_valid"}, 64'(get_sv(which)), 64'd1);
        chk({tag, "_sum"}, get_sum(which), esum);
        chk({tag, "_ovf"}, 64'((which == 0) ? ovf_a : ovf_b), 64'(eovf));
        chk({tag, "_pops"}, 64'(get_pops(which) - p0), 64'(w.size()));
        if (exp_lat >= 0) chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        if (do_ack) ack(which, tag);
    endtask

    task automatic feed(input int which, input wq_t w);
        foreach (w[i]) begin
            repeat ($urandom_range(0, 2)) tick;
            push(which, w[i]);
        end
    endtask

    vec_t        vecs[5];
    wq_t         q;
    logic [63:0] es, hold_sum;
    logic        eo;
    int          lat, p0, n;

    initial begin
        aclr_n = 1'b0;
        start_a = 0; start_b = 0; rdy_a = 0; rdy_b = 0; len_a = 0; len_b = 0;
        #1;
        chk("rst_pop", 64'(pop_a), 0);
        chk("rst_busy", 64'(busy_a), 0);
        chk("rst_valid", 64'(sv_a), 0);
        chk("rst_ovf", 64'(ovf_a), 0);
        chk("rst_sum", get_sum(0), 0);
        tick; tick;
        aclr_n = 1'b1;

        // Directed vectors on the 40-bit instance, FIFO preloaded.
        vecs[0] = '{4, {32'd4, 32'd3, 32'd2, 32'd1}, 64'd10, 1'b0, 6};
        vecs[1] = '{0, '0, 64'd0, 1'b0, 1};
        vecs[2] = '{1, {96'd0, 32'hFFFF_FFFB}, 64'hFF_FFFF_FFFB, 1'b0, 3};
        vecs[3] = '{3, {32'd0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000},
                    64'hFE_8000_0000, 1'b0, 5};
        vecs[4] = '{2, {64'd0, 32'd1, 32'h7FFF_FFFF}, 64'h80_0000_00, 1'b0, 4};
        for (int k = 0; k < 5; k++) begin
            q.delete();
            for (int j = 0; j < vecs[k].len; j++) begin
                q.push_back(vecs[k].w[j]);
                push(0, vecs[k].w[j]);
            end
            job_check(0, $sformatf("vec%0d", k), q, vecs[k].exp_sum,
                      vecs[k].exp_ovf, vecs[k].exp_lat, 1'b1, lat);
        end

        // FIFO runs dry after two words and is refilled later.
        q = '{32'd2, 32'd3, 32'd5, 32'd6};
        push(0, 32'd2); push(0, 32'd3);
        fork
            job_check(0, "stall", q, 64'd16, 1'b0, -1, 1'b1, lat);
            begin
                repeat (5) tick;
                push(0, 32'd5); push(0, 32'd6);
            end
        join
        chk("stall_latency_longer", 64'(lat > 6), 64'd1);

        // Result held under back-pressure; Start ignored; Start+SumReady together.
        q = '{32'd7, 32'd8};
        push(0, 32'd7); push(0, 32'd8);
        job_check(0, "hold", q, 64'd15, 1'b0, 4, 1'b0, lat);
        hold_sum = get_sum(0);
        n = 0;
        for (int c = 0; c < 5; c++) begin
            start_a = c[0];
            rdy_a   = 1'b0;
            tick;
            if (sv_a === 1'b1 && get_sum(0) === hold_sum && busy_a === 1'b1) n++;
        end
        start_a = 1'b0;
        chk("hold_stable_cycles", 64'(n), 64'd5);
        rdy_a = 1'b1; start_a = 1'b1;
        tick;
        rdy_a = 1'b0; start_a = 1'b0;
        chk("hold_ready_valid", 64'(sv_a), 0);
        chk("hold_ready_start_ignored", 64'(busy_a), 0);
        tick;
        chk("hold_sum_kept_idle", get_sum(0), hold_sum);
        chk("hold_no_pop_idle", 64'(pop_a), 0);

        // Reset in the middle of a drain.
        p0 = pops_a;
        push(0, 32'd1); push(0, 32'd2); push(0, 32'd3); push(0, 32'd4);
        drive(0, 1'b1, 8'd4);
        tick;
        drive(0, 1'b0, 8'd0);
        n = 0;
        while (pops_a - p0 < 2 && n < 20) begin tick; n++; end
        chk("abort_two_pops", 64'(pops_a - p0), 64'd2);
        aclr_n = 1'b0;
        #1;
        chk("abort_pop", 64'(pop_a), 0);
        chk("abort_busy", 64'(busy_a), 0);
        chk("abort_valid", 64'(sv_a), 0);
        chk("abort_sum", get_sum(0), 0);
        tick;
        aclr_n = 1'b1;
        q = '{32'd3, 32'd4};
        job_check(0, "after_abort", q, 64'd7, 1'b0, 4, 1'b1, lat);

        // 33-bit accumulator: in-range, overflowing and negative sums.
        q = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        foreach (q[i]) push(1, q[i]);
        job_check(1, "w33_maxpos2", q, 64'h0_FFFF_FFFE, 1'b0, 4, 1'b1, lat);
        q = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        foreach (q[i]) push(1, q[i]);
        job_check(1, "w33_maxpos3", q, 64'h1_7FFF_FFFD, 1'b1, 5, 1'b1, lat);
        q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        foreach (q[i]) push(1, q[i]);
        job_check(1, "w33_neg", q, 64'h1_FFFF_FFFE, 1'b0, 4, 1'b1, lat);

        // Random jobs with a trickling FIFO on the 40-bit instance.
        for (int r = 0; r < 25; r++) begin
            q.delete();
            n = $urandom_range(0, 10);
            for (int j = 0; j < n; j++) q.push_back($urandom);
            model(40, q, es, eo);
            fork
                feed(0, q);
                job_check(0, $sformatf("rndA%0d", r), q, es, eo, -1, 1'b1, lat);
            join
        end

        // Random preloaded jobs on the 33-bit instance exercise overflow.
        for (int r = 0; r < 15; r++) begin
            q.delete();
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) q.push_back($urandom);
            foreach (q[i]) push(1, q[i]);
            model(33, q, es, eo);
            job_check(1, $sformatf("rndB%0d", r), q, es, eo, n + 2, 1'b1, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
